// File: rtl/board_io_bridge.sv
// Board I/O bridge: synchronized, debounced push-button capture of the switch word into a
// valid/ready sample, plus a registered channel display mux. Optional scan mode: IO_BRIDGE_SCAN_EN.
module board_io_bridge #(
    parameter int IN_W     = 10,
    parameter int OUT_W    = 16,
    parameter int NCH      = 4,
    parameter int DEB_CYC  = 4,
    parameter int SCAN_CYC = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       select,
    input  logic [IN_W-1:0]            inp,
    input  logic                       in_ready,
    output logic                       in_valid,
    output logic [IN_W-1:0]            in_data,
    input  logic [NCH*OUT_W-1:0]       ch_data,
    input  logic [$clog2(NCH)-1:0]     ch_sel,
    input  logic                       scan,
    output logic [OUT_W-1:0]           out,
    output logic [$clog2(NCH)-1:0]     ch_idx,
    output logic                       ovf
);

    localparam int SEL_W = $clog2(NCH);
    localparam int DEB_W = $clog2(DEB_CYC);

    logic              sel_s1, sel_s2;
    logic [IN_W-1:0]   inp_s1, inp_s2;
    logic              db;
    logic [DEB_W-1:0]  deb_cnt;
    logic              db_hit;
    logic              press;
    logic              xfer;

    logic              valid_nxt;
    logic [IN_W-1:0]   data_nxt;
    logic              ovf_nxt;

    logic [SEL_W-1:0]  idx_nxt;
    logic [OUT_W-1:0]  out_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_s1 <= 1'b0;
            sel_s2 <= 1'b0;
            inp_s1 <= '0;
            inp_s2 <= '0;
        end else begin
            sel_s1 <= select;
            sel_s2 <= sel_s1;
            inp_s1 <= inp;
            inp_s2 <= inp_s1;
        end
    end

    // deb_cnt is a down-counter: 0 means idle, the first disagreeing edge loads DEB_CYC-1,
    // and the edge that finds it at 1 is the DEB_CYC-th consecutive disagreement.
    assign db_hit = (sel_s2 != db) && (deb_cnt == DEB_W'(1));
    assign press  = db_hit && sel_s2;
    assign xfer   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db      <= 1'b0;
            deb_cnt <= '0;
        end else if (sel_s2 == db) begin
            deb_cnt <= '0;
        end else if (db_hit) begin
            db      <= sel_s2;
            deb_cnt <= '0;
        end else if (deb_cnt == '0) begin
            deb_cnt <= DEB_W'(DEB_CYC - 1);
        end else begin
            deb_cnt <= deb_cnt - 1'b1;
        end
    end

    // A press can only land when the slot is empty or being emptied on this same edge.
    always_comb begin
        valid_nxt = in_valid;
        data_nxt  = in_data;
        ovf_nxt   = ovf;
        if (press) begin
            if (!in_valid || xfer) begin
                valid_nxt = 1'b1;
                data_nxt  = inp_s2;
            end else begin
                ovf_nxt = 1'b1;
            end
        end else if (xfer) begin
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_valid <= 1'b0;
            in_data  <= '0;
            ovf      <= 1'b0;
        end else begin
            in_valid <= valid_nxt;
            in_data  <= data_nxt;
            ovf      <= ovf_nxt;
        end
    end

`ifdef IO_BRIDGE_SCAN_EN
    localparam int SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_tc;

    assign scan_tc = (scan_cnt == SCAN_W'(SCAN_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (!scan || scan_tc) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // NCH is a power of two, so the increment wraps NCH-1 -> 0 on its own.
    always_comb begin
        idx_nxt = ch_sel;
        if (scan) begin
            idx_nxt = scan_tc ? ch_idx + 1'b1 : ch_idx;
        end
    end
`else
    logic unused_scan;
    assign unused_scan = scan;

    always_comb begin
        idx_nxt = ch_sel;
    end
`endif

    always_comb begin
        out_nxt = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx_nxt == SEL_W'(k)) begin
                out_nxt = ch_data[k*OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out    <= '0;
            ch_idx <= '0;
        end else begin
            out    <= out_nxt;
            ch_idx <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_board_io_bridge.sv
// Directed bench for board_io_bridge (NCH=4, DEB_CYC=4, IN_W=10, OUT_W=16, SCAN_CYC=8).
module tb_board_io_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        select;
    logic [9:0]  inp;
    logic        in_ready;
    logic        in_valid;
    logic [9:0]  in_data;
    logic [63:0] ch_data;
    logic [1:0]  ch_sel;
    logic        scan;
    logic [15:0] out;
    logic [1:0]  ch_idx;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    board_io_bridge #(
        .IN_W(10), .OUT_W(16), .NCH(4), .DEB_CYC(4), .SCAN_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .select(select), .inp(inp),
        .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
        .ch_data(ch_data), .ch_sel(ch_sel), .scan(scan),
        .out(out), .ch_idx(ch_idx), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".in_valid"}, 32'(in_valid), 32'h0);
        chk({tag, ".in_data"},  32'(in_data),  32'h0);
        chk({tag, ".out"},      32'(out),      32'h0);
        chk({tag, ".ch_idx"},   32'(ch_idx),   32'h0);
        chk({tag, ".ovf"},      32'(ovf),      32'h0);
    endtask

    initial begin
        rst      = 1'b1;
        select   = 1'b0;
        inp      = '0;
        in_ready = 1'b0;
        ch_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        ch_sel   = 2'd0;
        scan     = 1'b0;
        tick(2);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(3);
        chk("idle.out", 32'(out), 32'h1111);

        // bouncing button never settles long enough
        for (int i = 0; i < 20; i++) begin
            select = ~select;
            tick(1);
        end
        select = 1'b0;
        tick(8);
        chk("bounce.in_valid", 32'(in_valid), 32'h0);
        chk("bounce.ovf",      32'(ovf),      32'h0);

        // clean press: 2 sync + 4 debounce edges
        inp    = 10'h2A5;
        select = 1'b1;
        tick(5);
        chk("press.early_valid", 32'(in_valid), 32'h0);
        tick(1);
        chk("press.valid", 32'(in_valid), 32'h1);
        chk("press.data",  32'(in_data),  32'h2A5);
        inp = 10'h000;
        tick(5);
        chk("hold.valid", 32'(in_valid), 32'h1);
        chk("hold.data",  32'(in_data),  32'h2A5);
        chk("hold.ovf",   32'(ovf),      32'h0);
        select = 1'b0;
        tick(8);
        chk("release.valid", 32'(in_valid), 32'h1);

        // second press while full and not ready -> dropped
        inp    = 10'h0F0;
        select = 1'b1;
        tick(8);
        chk("drop.data",  32'(in_data),  32'h2A5);
        chk("drop.valid", 32'(in_valid), 32'h1);
        chk("drop.ovf",   32'(ovf),      32'h1);
        in_ready = 1'b1;
        tick(1);
        in_ready = 1'b0;
        chk("xfer.valid", 32'(in_valid), 32'h0);
        chk("xfer.ovf",   32'(ovf),      32'h1);
        select = 1'b0;
        tick(8);

        // refill, then async reset with valid and ovf set
        inp    = 10'h3C3;
        ch_sel = 2'd3;
        select = 1'b1;
        tick(6);
        chk("refill.valid",  32'(in_valid), 32'h1);
        chk("refill.data",   32'(in_data),  32'h3C3);
        chk("refill.ovf",    32'(ovf),      32'h1);
        chk("refill.ch_idx", 32'(ch_idx),   32'h3);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        chk("post_rst.out",    32'(out),    32'h4444);
        chk("post_rst.ch_idx", 32'(ch_idx), 32'h3);
        tick(4);
        chk("post_rst.early_valid", 32'(in_valid), 32'h0);
        tick(1);
        chk("post_rst.valid", 32'(in_valid), 32'h1);
        chk("post_rst.data",  32'(in_data),  32'h3C3);
        chk("post_rst.ovf",   32'(ovf),      32'h0);

        // press lands on the same edge as a transfer
        select = 1'b0;
        tick(8);
        inp    = 10'h155;
        select = 1'b1;
        tick(5);
        in_ready = 1'b1;
        tick(1);
        in_ready = 1'b0;
        chk("same_edge.valid", 32'(in_valid), 32'h1);
        chk("same_edge.data",  32'(in_data),  32'h155);
        chk("same_edge.ovf",   32'(ovf),      32'h0);
        in_ready = 1'b1;
        tick(1);
        in_ready = 1'b0;
        chk("drain.valid", 32'(in_valid), 32'h0);

        // display mux latency
        ch_sel = 2'd2;
        #1;
        chk("mux.before_edge", 32'(out), 32'h4444);
        @(negedge clk);
        chk("mux.sel2.out",    32'(out),    32'h3333);
        chk("mux.sel2.ch_idx", 32'(ch_idx), 32'h2);
        ch_sel = 2'd1;
        tick(1);
        chk("mux.sel1.out",    32'(out),    32'h2222);
        chk("mux.sel1.ch_idx", 32'(ch_idx), 32'h1);
        ch_data[31:16] = 16'hBEEF;
        tick(1);
        chk("mux.live.out", 32'(out), 32'hBEEF);
        ch_data[31:16] = 16'h2222;
        ch_sel = 2'd0;
        tick(2);

`ifdef IO_BRIDGE_SCAN_EN
        scan = 1'b1;
        tick(7);
        chk("scan.hold", 32'(out), 32'h1111);
        tick(1);
        chk("scan.ch1", 32'(out), 32'h2222);
        tick(8);
        chk("scan.ch2", 32'(out), 32'h3333);
        tick(8);
        chk("scan.ch3", 32'(out), 32'h4444);
        tick(8);
        chk("scan.wrap",    32'(out),    32'h1111);
        chk("scan.wrap_ix", 32'(ch_idx), 32'h0);
        ch_sel = 2'd2;
        scan   = 1'b0;
        tick(1);
        chk("scan.exit.out", 32'(out),    32'h3333);
        chk("scan.exit.idx", 32'(ch_idx), 32'h2);
`else
        scan   = 1'b1;
        ch_sel = 2'd1;
        tick(20);
        chk("scan_off.out",    32'(out),    32'h2222);
        chk("scan_off.ch_idx", 32'(ch_idx), 32'h1);
        scan = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/board_io_bridge.md
BOARD_IO_BRIDGE -- requirements
Module: board_io_bridge

Interface
REQ-001 Parameter IN_W, default 10, width of switch input word delivered to the core.
REQ-002 Parameter OUT_W, default 16, width of each observed channel and of out.
REQ-003 Parameter NCH, default 4, number of core channels selectable for display (power of 2, >=2).
REQ-004 Parameter DEB_CYC, default 4, consecutive stable cycles required to accept a button level change (>=2).
REQ-005 Parameter SCAN_CYC, default 8, cycles per channel in scan mode (>=1).
REQ-006 clk  in  1  single system clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 select  in  1  raw board push-button, asynchronous to clk, bouncing.
REQ-009 inp  in  IN_W  raw board switches, asynchronous to clk.
REQ-010 in_ready  in  1  core accepts in_data this cycle.
REQ-011 in_valid  out  1  in_data holds an unconsumed sample.
REQ-012 in_data  out  IN_W  captured switch word.
REQ-013 ch_data  in  NCH*OUT_W  core observation bus, channel k at bits [k*OUT_W +: OUT_W].
REQ-014 ch_sel  in  log2(NCH)  manual display channel.
REQ-015 scan  in  1  scan-mode request (used only under IO_BRIDGE_SCAN_EN).
REQ-016 out  out  OUT_W  registered display word.
REQ-017 ch_idx  out  log2(NCH)  channel currently driving out.
REQ-018 ovf  out  1  sticky: a press was dropped.

Function
REQ-019 select and inp SHALL each pass a 2-flop synchronizer before any other use.
REQ-020 Debounced level db SHALL change only after the synchronized select differs from db on DEB_CYC consecutive rising edges; any cycle of agreement SHALL clear the stability counter.
REQ-021 A db 0->1 transition is a press; on that same edge in_data SHALL load the synchronized inp and in_valid SHALL set.
REQ-022 db 1->0 transitions SHALL produce no action.
REQ-023 Handshake: transfer occurs on an edge with in_valid=1 and in_ready=1; in_valid SHALL clear on that edge unless a press occurs on the same edge.
REQ-024 Press on same edge as transfer: in_valid SHALL stay 1, in_data SHALL load the new word, ovf unchanged.
REQ-025 Press while in_valid=1 and in_ready=0: press SHALL be dropped, in_data SHALL hold, ovf SHALL set and stay set until reset.
REQ-026 in_data SHALL be stable while in_valid=1 and no transfer occurs.
REQ-027 out SHALL register channel ch_idx of ch_data with exactly 1-cycle latency; ch_idx SHALL be registered alongside out.
REQ-028 Manual mode: ch_idx SHALL follow ch_sel with 1-cycle latency.

Reset
REQ-029 rst=1 SHALL immediately force in_valid=0, in_data=0, out=0, ch_idx=0, ovf=0, db=0, debounce counter=0, scan counter=0, synchronizer flops=0.
REQ-030 Reset asserted mid-debounce or with in_valid=1 SHALL discard the pending sample; first press after release SHALL require the full synchronizer plus DEB_CYC delay.

Configuration
REQ-031 Macro IO_BRIDGE_SCAN_EN defined: when scan=1, ch_idx SHALL advance by 1 every SCAN_CYC cycles, wrapping NCH-1 -> 0; when scan returns to 0, manual mode resumes next cycle and the scan counter SHALL reset to 0.
REQ-032 Macro IO_BRIDGE_SCAN_EN undefined: scan SHALL be ignored, no scan counter SHALL be synthesized, ch_idx always follows ch_sel.

Verification (NCH=4, DEB_CYC=4, IN_W=10, OUT_W=16, SCAN_CYC=8)
REQ-033 inp=0x2A5, select held 1 from cycle 0, in_ready=0 -> in_valid=1, in_data=0x2A5 after cycle 6 (2 sync + 4 debounce), held thereafter.
REQ-034 select toggles every cycle for 20 cycles then 0 -> in_valid stays 0, ovf=0.
REQ-035 in_valid=1, second clean press with in_ready=0 -> in_data unchanged, ovf=1; in_ready=1 one cycle -> in_valid=0, ovf stays 1.
REQ-036 Press completing on same edge as in_ready=1 with inp=0x155 -> in_valid stays 1, in_data=0x155, ovf=0.
REQ-037 ch_data channels = 0x1111/0x2222/0x3333/0x4444, ch_sel=2 -> out=0x3333, ch_idx=2 one cycle later; with IO_BRIDGE_SCAN_EN and scan=1, out steps 0x1111,0x2222,0x3333,0x4444,0x1111 at 8-cycle intervals.
REQ-038 rst pulsed 1 cycle while in_valid=1 and ovf=1 -> all outputs 0 asynchronously, before next clock edge.
